// File: rtl/svc_rv_io_uart.sv
// MMIO byte-stream UART front end: TX FIFO drained over a valid/ready byte
// stream, single-byte RX holding register, and a STATUS word with sticky overflow.
module svc_rv_io_uart #(
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        utx_valid,
    output logic [7:0]  utx_data,
    input  logic        utx_ready,
    input  logic        urx_valid,
    input  logic [7:0]  urx_data,
    output logic        urx_ready
);

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_RXDATA = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    tx_mem [TX_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    logic          tx_ovf;
    logic          tx_full;
    logic          tx_empty;
    logic          wr_tx;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;

    logic          rx_full;
    logic          rx_full_next;
    logic [7:0]    rx_byte;
    logic          rx_capture;
    logic          rx_pop;
    logic [31:0]   rdata_next;

    reg_sel_e      wsel;
    reg_sel_e      rsel;

    logic          unused_bits;

    assign wsel = reg_sel_e'(io_waddr[3:2]);
    assign rsel = reg_sel_e'(io_raddr[3:2]);

    assign tx_full   = (count == CW'(TX_DEPTH));
    assign tx_empty  = (count == '0);
    assign utx_valid = !tx_empty;
    assign utx_data  = tx_mem[rptr];
    assign count8    = 8'(count);

    // A write to a full FIFO is still accepted when the head leaves in the same cycle.
    assign pop     = utx_valid && utx_ready;
    assign wr_tx   = io_wen && (wsel == REG_TXDATA) && io_wstrb[0];
    assign push    = wr_tx && (!tx_full || pop);
    assign ovf_set = wr_tx && !push;
    assign ovf_clr = io_wen && (wsel == REG_STATUS) && io_wstrb[0] && io_wdata[3];

    always_ff @(posedge clk) begin
        if (push) begin
            tx_mem[wptr] <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set)      tx_ovf <= 1'b1;
            else if (ovf_clr) tx_ovf <= 1'b0;
        end
    end

    assign rx_capture = urx_valid && urx_ready;
    assign rx_pop     = io_ren && (rsel == REG_RXDATA) && rx_full;

    always_comb begin
        rx_full_next = rx_full;
        if (rx_capture) rx_full_next = 1'b1;
        if (rx_pop)     rx_full_next = 1'b0;
    end

    // urx_ready is registered so it stays low out of reset and through the pop cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full   <= 1'b0;
            rx_byte   <= '0;
            urx_ready <= 1'b0;
        end else begin
            rx_full   <= rx_full_next;
            urx_ready <= !rx_full_next;
            if (rx_capture) rx_byte <= urx_data;
        end
    end

    always_comb begin
        rdata_next = '0;
        case (rsel)
            REG_STATUS: rdata_next = {16'b0, count8, 4'b0, tx_ovf, rx_full, tx_empty, tx_full};
            REG_RXDATA: rdata_next = rx_full ? {23'b0, 1'b1, rx_byte} : '0;
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= '0;
        end else if (io_ren) begin
            io_rdata <= rdata_next;
        end
    end

    assign unused_bits = ^{io_raddr[31:4], io_raddr[1:0], io_waddr[31:4], io_waddr[1:0],
                           io_wdata[31:8], io_wstrb[3:1]};

endmodule

// File: tb/tb_svc_rv_io_uart.sv
// Directed bench for svc_rv_io_uart: TX FIFO ordering/overflow, RX holding
// register, STATUS encoding and asynchronous reset behaviour.
module tb_svc_rv_io_uart;

    logic        clk;
    logic        rst_n;
    logic        io_ren;
    logic [31:0] io_raddr;
    logic [31:0] io_rdata;
    logic        io_wen;
    logic [31:0] io_waddr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        utx_valid;
    logic [7:0]  utx_data;
    logic        utx_ready;
    logic        urx_valid;
    logic [7:0]  urx_data;
    logic        urx_ready;

    int unsigned vec_cnt;
    int unsigned miscompare_cnt;
    logic [31:0] d;

    localparam logic [31:0] A_TX   = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_RX   = 32'h8;
    localparam logic [31:0] A_RSVD = 32'hC;

    svc_rv_io_uart #(.TX_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_ren    (io_ren),
        .io_raddr  (io_raddr),
        .io_rdata  (io_rdata),
        .io_wen    (io_wen),
        .io_waddr  (io_waddr),
        .io_wdata  (io_wdata),
        .io_wstrb  (io_wstrb),
        .utx_valid (utx_valid),
        .utx_data  (utx_data),
        .utx_ready (utx_ready),
        .urx_valid (urx_valid),
        .urx_data  (urx_data),
        .urx_ready (urx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        io_wen   = 1'b1;
        io_waddr = addr;
        io_wdata = data;
        io_wstrb = strb;
        tick();
        io_wen   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        io_ren   = 1'b1;
        io_raddr = addr;
        tick();
        io_ren   = 1'b0;
        data     = io_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_cnt = 0;
        miscompare_cnt = 0;
        rst_n = 1'b0;
        io_ren = 1'b0; io_raddr = '0;
        io_wen = 1'b0; io_waddr = '0; io_wdata = '0; io_wstrb = '0;
        utx_ready = 1'b0; urx_valid = 1'b0; urx_data = '0;

        #3;
        check("rst_utx_valid", 32'(utx_valid), 32'd0);
        check("rst_urx_ready", 32'(urx_ready), 32'd0);
        check("rst_rdata", io_rdata, 32'h0);
        #19 rst_n = 1'b1;
        tick();
        check("post_rst_urx_ready", 32'(urx_ready), 32'd1);

        // Two bytes back to back with the sink always ready
        utx_ready = 1'b1;
        io_wen = 1'b1; io_waddr = A_TX; io_wdata = 32'h41; io_wstrb = 4'h1;
        tick();
        check("tx1_valid", 32'(utx_valid), 32'd1);
        check("tx1_data", 32'(utx_data), 32'h41);
        io_wdata = 32'h42;
        tick();
        io_wen = 1'b0;
        check("tx2_valid", 32'(utx_valid), 32'd1);
        check("tx2_data", 32'(utx_data), 32'h42);
        tick();
        check("tx_drained", 32'(utx_valid), 32'd0);
        utx_ready = 1'b0;
        rd(A_STAT, d);
        check("stat_idle", d, 32'h0000_0002);

        // Overflow: five writes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h10 + 32'(i), 4'h1);
        rd(A_STAT, d);
        check("stat_ovf_full", d, 32'h0000_0409);
        check("hold_head", 32'(utx_data), 32'h10);
        tick();
        check("hold_head2", 32'(utx_data), 32'h10);
        utx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(utx_valid), 32'd1);
            check("drain_data", 32'(utx_data), 32'h10 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(utx_valid), 32'd0);
        utx_ready = 1'b0;
        rd(A_STAT, d);
        check("stat_ovf_empty", d, 32'h0000_000A);
        wr(A_STAT, 32'h8, 4'hE);
        rd(A_STAT, d);
        check("ovf_noclr_strb", d, 32'h0000_000A);
        wr(A_STAT, 32'h8, 4'h1);
        rd(A_STAT, d);
        check("ovf_cleared", d, 32'h0000_0002);
        wr(A_TX, 32'h99, 4'hE);
        check("tx_strb0_noop", 32'(utx_valid), 32'd0);
        rd(A_STAT, d);
        check("stat_strb0", d, 32'h0000_0002);

        // Push on full with a same-cycle pop
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h20 + 32'(i), 4'h1);
        rd(A_STAT, d);
        check("stat_full", d, 32'h0000_0401);
        utx_ready = 1'b1;
        wr(A_TX, 32'h24, 4'h1);
        utx_ready = 1'b0;
        rd(A_STAT, d);
        check("stat_full_pp", d, 32'h0000_0401);
        utx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_data", 32'(utx_data), 32'h21 + 32'(i));
            tick();
        end
        check("pp_empty", 32'(utx_valid), 32'd0);
        utx_ready = 1'b0;

        // Concurrent read of STATUS and write of TXDATA
        io_ren = 1'b1; io_raddr = A_STAT;
        io_wen = 1'b1; io_waddr = A_TX; io_wdata = 32'h55; io_wstrb = 4'h1;
        tick();
        io_ren = 1'b0; io_wen = 1'b0;
        check("conc_rdata", io_rdata, 32'h0000_0002);
        rd(A_STAT, d);
        check("conc_after", d, 32'h0000_0100);
        utx_ready = 1'b1;
        check("conc_byte", 32'(utx_data), 32'h55);
        tick();
        utx_ready = 1'b0;
        check("conc_empty", 32'(utx_valid), 32'd0);

        // RX holding register
        check("rx_ready_idle", 32'(urx_ready), 32'd1);
        urx_valid = 1'b1; urx_data = 8'h5A;
        tick();
        check("rx_ready_full", 32'(urx_ready), 32'd0);
        urx_data = 8'h77;
        tick();
        urx_valid = 1'b0;
        rd(A_STAT, d);
        check("stat_rx_full", d, 32'h0000_0006);
        io_ren = 1'b1; io_raddr = A_RX;
        check("rx_ready_popcyc", 32'(urx_ready), 32'd0);
        tick();
        io_ren = 1'b0;
        check("rx_data", io_rdata, 32'h0000_015A);
        check("rx_ready_after", 32'(urx_ready), 32'd1);
        rd(A_RX, d);
        check("rx_empty_read", d, 32'h0);
        rd(A_STAT, d);
        check("stat_after_rx", d, 32'h0000_0002);
        tick();
        check("rdata_hold", io_rdata, 32'h0000_0002);
        rd(A_RSVD, d);
        check("rsvd_read", d, 32'h0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) wr(A_TX, 32'h30 + 32'(i), 4'h1);
        urx_valid = 1'b1; urx_data = 8'h66;
        tick();
        urx_valid = 1'b0;
        rd(A_STAT, d);
        check("stat_pre_rst", d, 32'h0000_0304);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(utx_valid), 32'd0);
        check("rst_async_urx", 32'(urx_ready), 32'd0);
        check("rst_async_rdata", io_rdata, 32'h0);
        #20 rst_n = 1'b1;
        tick();
        check("rst_no_emit", 32'(utx_valid), 32'd0);
        rd(A_STAT, d);
        check("stat_post_rst", d, 32'h0000_0002);
        rd(A_RX, d);
        check("rx_post_rst", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
